slow_window: RTL and testbench

Downstream consumer of the slow-mode configuration register. Watches each CPU bus cycle. When a cycle hits a peripheral class whose Slow* enable is set, it requests CPU slow-down for the whole access. It then holds that request for a programmable window of SlowTimeout × TICK_DIV clocks, so that software timing loops around I/O run at stock speed. SlowReq feeds the clock-switch logic; ClockGate feeds the CPU clock gate.

---
 rtl/slow_window_pkg.sv | 19 +
 rtl/slow_prescaler.sv | 37 +++
 rtl/slow_window.sv | 126 ++++++++++++
 tb/tb_slow_window.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/slow_window_pkg.sv
// Shared definitions for the slow-mode request window: the state encoding
// and the SlowTimeout value that selects the sticky mode.
package slow_window_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        STICKY = 2'd3
    } state_e;

    localparam int unsigned  CNT_W       = 4;
    localparam logic [3:0]   STICKY_CODE = 4'hF;

    function automatic logic is_holding(input state_e s);
        return (s == HOLD) || (s == STICKY);
    endfunction

endpackage

// File: rtl/slow_prescaler.sv
// Down-counter that divides the clock into timeout ticks. It loads TICK_DIV-1,
// counts down while enabled, and pulses tick on the enabled clock at zero.
module slow_prescaler #(
    parameter int unsigned PRE_W    = 8,
    parameter int unsigned TICK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam logic [PRE_W-1:0] RELOAD = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // The terminal clock reloads rather than wrapping, so pre never underflows.
    always_comb begin
        pre_d = pre_q;
        tick  = en && (pre_q == '0);
        if (load) begin
            pre_d = RELOAD;
        end else if (en) begin
            pre_d = (pre_q == '0) ? RELOAD : pre_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/slow_window.sv
// Requests CPU slow-down for the duration of slow-class bus accesses and for
// a programmable window afterwards, or indefinitely while SlowTimeout is F.
module slow_window
    import slow_window_pkg::*;
#(
    parameter int unsigned TICK_DIV = 16,
    parameter int unsigned PRE_W    = 8
) (
    input  logic       CLK,
    input  logic       POR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       SlowReq,
    output logic       ClockGate,
    output logic       Holding
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             slow_req_q, slow_req_d;
    logic             clock_gate_q, clock_gate_d;
    logic             holding_q, holding_d;
    logic             hit;
    logic             pre_load, pre_en, pre_tick;

    assign hit = BACT && ((IACKCS && SlowIACK) || (VIACS  && SlowVIA)  ||
                          (IWMCS  && SlowIWM)  || (SCCCS  && SlowSCC)  ||
                          (SCSICS && SlowSCSI) || (SndCS  && SlowSnd));

    // A hit during HOLD freezes the prescaler; it reloads when that access ends.
    assign pre_en   = (state_q == HOLD) && !hit;
    assign pre_load = (state_q == ACCESS) && (state_d == HOLD);

    slow_prescaler #(
        .PRE_W    (PRE_W),
        .TICK_DIV (TICK_DIV)
    ) u_pre (
        .clk  (CLK),
        .rst  (POR),
        .load (pre_load),
        .en   (pre_en),
        .tick (pre_tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACCESS;
                end else if (SlowTimeout == STICKY_CODE) begin
                    state_d = STICKY;
                end
            end
            ACCESS: begin
                if (!BACT) begin
                    if (SlowTimeout == '0) begin
                        state_d = IDLE;
                    end else if (SlowTimeout == STICKY_CODE) begin
                        state_d = STICKY;
                    end else begin
                        state_d = HOLD;
                        count_d = SlowTimeout;
                    end
                end
            end
            HOLD: begin
                if (hit) begin
                    state_d = ACCESS;
                end else if (pre_tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end
                    if (count_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            STICKY: begin
                if (SlowTimeout != STICKY_CODE) begin
                    state_d = hit ? ACCESS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        slow_req_d   = (state_d != IDLE);
        clock_gate_d = slow_req_d && SlowClockGate;
        holding_d    = is_holding(state_d);
    end

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state_q      <= IDLE;
            count_q      <= '0;
            slow_req_q   <= 1'b0;
            clock_gate_q <= 1'b0;
            holding_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            slow_req_q   <= slow_req_d;
            clock_gate_q <= clock_gate_d;
            holding_q    <= holding_d;
        end
    end

    assign SlowReq   = slow_req_q;
    assign ClockGate = clock_gate_q;
    assign Holding   = holding_q;

endmodule

// File: tb/tb_slow_window.sv
// Directed bench for slow_window: stimulus queues the expected outputs for
// each clock, a negedge monitor pops and compares them.
module tb_slow_window;

    logic       CLK = 1'b0;
    logic       POR = 1'b1;
    logic       BACT = 1'b0;
    logic       IACKCS = 1'b0, VIACS = 1'b0, IWMCS = 1'b0;
    logic       SCCCS = 1'b0, SCSICS = 1'b0, SndCS = 1'b0;
    logic       SlowIACK = 1'b0, SlowVIA = 1'b0, SlowIWM = 1'b0;
    logic       SlowSCC = 1'b0, SlowSCSI = 1'b0, SlowSnd = 1'b0;
    logic       SlowClockGate = 1'b0;
    logic [3:0] SlowTimeout = 4'hF;
    logic       SlowReq, ClockGate, Holding;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic  r;
        logic  c;
        logic  h;
        string nm;
    } exp_t;

    exp_t exp_q[$];

    slow_window #(.TICK_DIV(16), .PRE_W(8)) dut (
        .CLK(CLK), .POR(POR), .BACT(BACT),
        .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS),
        .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS),
        .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM),
        .SlowSCC(SlowSCC), .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd),
        .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout),
        .SlowReq(SlowReq), .ClockGate(ClockGate), .Holding(Holding)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string nm, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b at %0t", nm, act, want, $time);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".SlowReq"},   SlowReq,   e.r);
                chk({e.nm, ".ClockGate"}, ClockGate, e.c);
                chk({e.nm, ".Holding"},   Holding,   e.h);
            end
        end
    end

    // Queue the outputs expected after the next rising edge, then advance.
    task automatic cyc(input logic r, input logic c, input logic h,
                       input string nm, input int n = 1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.r = r; e.c = c; e.h = h;
            e.nm = $sformatf("%s[%0d]", nm, i);
            exp_q.push_back(e);
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic bus_idle();
        BACT = 1'b0;
        {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = 6'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while POR is held
        #12;
        chk("reset.SlowReq", SlowReq, 1'b0);
        chk("reset.ClockGate", ClockGate, 1'b0);
        chk("reset.Holding", Holding, 1'b0);
        @(negedge CLK); #1;
        POR = 1'b0;

        // Sticky power-up default, then leave sticky with no bus activity
        @(negedge CLK); #1;
        cyc(1, 0, 1, "por_sticky");
        SlowTimeout = 4'd3;
        cyc(0, 0, 0, "sticky_exit", 2);

        // Basic window: 4-clock VIA access, timeout 2 -> 32 hold clocks
        SlowTimeout = 4'd2; SlowVIA = 1'b1; SlowClockGate = 1'b1;
        BACT = 1'b1; VIACS = 1'b1;
        cyc(1, 1, 0, "basic_access", 4);
        bus_idle();
        cyc(1, 1, 1, "basic_hold", 32);
        cyc(0, 0, 0, "basic_end", 2);

        // Disabled class produces no request
        SlowClockGate = 1'b0;
        BACT = 1'b1; SCCCS = 1'b1;
        cyc(0, 0, 0, "scc_disabled", 3);
        bus_idle();
        cyc(0, 0, 0, "scc_after", 1);

        // Retrigger: IWM access at HOLD clock 10 restarts a 16-clock window
        SlowTimeout = 4'd1; SlowIWM = 1'b1;
        BACT = 1'b1; VIACS = 1'b1;
        cyc(1, 0, 0, "retrig_first", 2);
        bus_idle();
        cyc(1, 0, 1, "retrig_hold1", 9);
        BACT = 1'b1; IWMCS = 1'b1;
        cyc(1, 0, 0, "retrig_second", 2);
        bus_idle();
        cyc(1, 0, 1, "retrig_hold2", 16);
        cyc(0, 0, 0, "retrig_end", 2);

        // Zero timeout: request only for the access
        SlowTimeout = 4'd0; SlowSCSI = 1'b1;
        BACT = 1'b1; SCSICS = 1'b1;
        cyc(1, 0, 0, "zero_access", 3);
        bus_idle();
        cyc(0, 0, 0, "zero_end", 2);

        // Hit on the terminal HOLD clock wins over the exit to IDLE
        SlowTimeout = 4'd1; SlowSnd = 1'b1;
        BACT = 1'b1; SndCS = 1'b1;
        cyc(1, 0, 0, "term_access", 1);
        bus_idle();
        cyc(1, 0, 1, "term_hold", 16);
        BACT = 1'b1; SndCS = 1'b1;
        SlowTimeout = 4'd0;
        cyc(1, 0, 0, "term_hit", 1);
        bus_idle();
        cyc(0, 0, 0, "term_end", 1);

        // Sticky entry, hit inside sticky, then timeout leaves F with a hit
        SlowTimeout = 4'hF;
        cyc(1, 0, 1, "sticky_enter", 1);
        BACT = 1'b1; VIACS = 1'b1;
        cyc(1, 0, 1, "sticky_hit", 1);
        SlowTimeout = 4'd2;
        cyc(1, 0, 0, "sticky_leave_hit", 1);
        bus_idle();
        SlowTimeout = 4'd0;
        cyc(0, 0, 0, "sticky_leave_end", 1);

        // Back-to-back cycles with BACT never low form one access
        BACT = 1'b1; VIACS = 1'b1;
        cyc(1, 0, 0, "b2b_via", 2);
        VIACS = 1'b0;
        cyc(1, 0, 0, "b2b_gap", 1);
        IWMCS = 1'b1;
        cyc(1, 0, 0, "b2b_iwm", 1);
        bus_idle();
        cyc(0, 0, 0, "b2b_end", 1);

        // Async reset mid-HOLD with Count still 3
        SlowTimeout = 4'd3; SlowIACK = 1'b1; SlowClockGate = 1'b1;
        BACT = 1'b1; IACKCS = 1'b1;
        cyc(1, 1, 0, "por_access", 1);
        bus_idle();
        cyc(1, 1, 1, "por_hold", 5);
        #2;
        POR = 1'b1;
        #1;
        chk("por_async.SlowReq", SlowReq, 1'b0);
        chk("por_async.ClockGate", ClockGate, 1'b0);
        chk("por_async.Holding", Holding, 1'b0);
        @(negedge CLK); #1;
        POR = 1'b0;
        cyc(0, 0, 0, "por_after", 2);

        repeat (2) @(negedge CLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
